// File: rtl/log_sched_pkg.sv
// Shared types for the log event scheduler: event kinds, FSM states and the
// event record carried through the slot, FIFO and output register.
package log_sched_pkg;

   typedef enum logic [1:0] {
      SNAP  = 2'd0,
      TRUE  = 2'd1,
      FALSE = 2'd2
   } evt_kind_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } state_e;

   typedef struct packed {
      evt_kind_e   kind;
      logic [31:0] tstamp;
      logic        a;
      logic        b;
   } evt_t;

   localparam logic [15:0] DROP_MAX = 16'hFFFF;

endpackage

// File: rtl/log_evt_fifo.sv
// Small synchronous FIFO of event records for the compare path. A push into a
// full FIFO is accepted only when a pop frees an entry in the same cycle.
module log_evt_fifo
   import log_sched_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  evt_t din,
   input  logic pop,
   output evt_t dout,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);

   evt_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // Storage array; payload needs no reset
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      count <= count + (AW+1)'(1);
         else if (!do_push && do_pop) count <= count - (AW+1)'(1);
      end
   end

endmodule

// File: rtl/log_event_scheduler.sv
// Merges periodic a/b snapshots and operand compare results onto one
// valid/ready event channel with round-robin arbitration and drop counting.
module log_event_scheduler
   import log_sched_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int PERIOD     = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [DATA_W-1:0] op_i,
   input  logic [DATA_W-1:0] op_j,
   input  logic              sig_a,
   input  logic              sig_b,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [1:0]        evt_kind,
   output logic [31:0]       evt_time,
   output logic              evt_a,
   output logic              evt_b,
   output logic [15:0]       drop_cnt,
   output logic              busy
);

   localparam int            PW         = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [PW-1:0] PHASE_LAST = PW'(PERIOD - 1);

   function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
      logic [16:0] sum;
      sum = {1'b0, cnt} + {15'd0, inc};
      return sum[16] ? DROP_MAX : sum[15:0];
   endfunction

   state_e            state;
   state_e            state_nx;
   logic              active;
   logic [31:0]       time_cnt;
   logic [PW-1:0]     phase;
   logic [DATA_W-1:0] op_i_q;
   logic [DATA_W-1:0] op_j_q;
   logic              snap_full;
   evt_t              snap_slot;
   logic              snap_cap;
   logic              cmp_push;
   evt_t              cmp_evt;
   evt_t              fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop;
   logic              load;
   logic              grant_snap;
   logic              grant_fifo;
   logic              rr_ptr;      // 0: slot has priority, 1: FIFO has priority
   logic              snap_drop;
   logic              cmp_drop;
   evt_t              out_q;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // FSM next-state; captures only happen in PRIME and RUN
   always_comb begin
      state_nx = state;
      active   = 1'b0;
      case (state)
         IDLE:    if (en) state_nx = PRIME;
         PRIME: begin
            active   = 1'b1;
            state_nx = RUN;
         end
         RUN: begin
            active = 1'b1;
            if (!en) state_nx = DRAIN;
         end
         DRAIN: begin
            if (en) state_nx = RUN;
            else if (!snap_full && fifo_empty && !evt_valid) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign snap_cap = active && (phase == PHASE_LAST);
   assign cmp_push = (state == PRIME) ||
                     ((state == RUN) && ((op_i != op_i_q) || (op_j != op_j_q)));
   assign cmp_evt  = '{kind: (op_i == op_j) ? TRUE : FALSE, tstamp: time_cnt, a: 1'b0, b: 1'b0};

   // Timestamp, snapshot phase and operand history advance only while capturing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         time_cnt <= '0;
         phase    <= '0;
         op_i_q   <= '0;
         op_j_q   <= '0;
      end else if (active) begin
         time_cnt <= time_cnt + 32'd1;
         phase    <= (phase == PHASE_LAST) ? '0 : phase + PW'(1);
         op_i_q   <= op_i;
         op_j_q   <= op_j;
      end
   end

   // One-entry snapshot slot; a newer capture replaces an unsent one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_full <= 1'b0;
         snap_slot <= '0;
      end else if (snap_cap) begin
         snap_full <= 1'b1;
         snap_slot <= '{kind: SNAP, tstamp: time_cnt, a: sig_a, b: sig_b};
      end else if (grant_snap) begin
         snap_full <= 1'b0;
      end
   end

   log_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_cmp_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cmp_push),
      .din   (cmp_evt),
      .pop   (fifo_pop),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign load      = !evt_valid || evt_ready;
   assign fifo_pop  = grant_fifo;
   assign snap_drop = snap_cap && snap_full && !grant_snap;
   assign cmp_drop  = cmp_push && fifo_full && !fifo_pop;

   // Round-robin grant; a lone pending source wins regardless of rr_ptr
   always_comb begin
      grant_snap = 1'b0;
      grant_fifo = 1'b0;
      if (load) begin
         if (snap_full && !fifo_empty) begin
            grant_snap = !rr_ptr;
            grant_fifo = rr_ptr;
         end else begin
            grant_snap = snap_full;
            grant_fifo = !fifo_empty;
         end
      end
   end

   // Priority pointer moves to the source that lost the last grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          rr_ptr <= 1'b0;
      else if (grant_snap) rr_ptr <= 1'b1;
      else if (grant_fifo) rr_ptr <= 1'b0;
   end

   // Saturating count of overwritten snapshots and rejected compare events
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) drop_cnt <= '0;
      else        drop_cnt <= sat_add(drop_cnt, {1'b0, snap_drop} + {1'b0, cmp_drop});
   end

   // Output register; reloads only when empty or being accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_valid <= 1'b0;
         out_q     <= '0;
      end else if (load) begin
         evt_valid <= grant_snap || grant_fifo;
         if (grant_snap)      out_q <= snap_slot;
         else if (grant_fifo) out_q <= fifo_head;
      end
   end

   assign evt_kind = out_q.kind;
   assign evt_time = out_q.tstamp;
   assign evt_a    = out_q.a;
   assign evt_b    = out_q.b;
   assign busy     = (state != IDLE) || snap_full || !fifo_empty || evt_valid;

endmodule
